// File: rtl/ring_phase_monitor_if.sv
// rtl/ring_phase_monitor_if.sv - ring sample in, decoded phase/lock status out
//
// Bundles the ring counter sample and the monitor's status outputs.
//   ring        : 4-bit one-hot ring counter value (driven by master)
//   phase       : binary index of the last valid one-hot sample
//   phase_valid : last sample was one-hot
//   locked      : rotation verified
//   wrap        : one-cycle pulse per locked revolution
//   rev_count   : locked revolutions, wraps at 2^REV_W
//   err_count   : lock losses, saturating
//   resync      : one-cycle request to re-clear the ring counter
// master = ring source / status consumer, slave = the monitor.

interface ring_phase_monitor_if #(
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    logic [3:0]       ring;
    logic [1:0]       phase;
    logic             phase_valid;
    logic             locked;
    logic             wrap;
    logic [REV_W-1:0] rev_count;
    logic [ERR_W-1:0] err_count;
    logic             resync;

    modport master (
        output ring,
        input  phase, phase_valid, locked, wrap, rev_count, err_count, resync
    );

    modport slave (
        input  ring,
        output phase, phase_valid, locked, wrap, rev_count, err_count, resync
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - verifies one-step rotation of a 4-bit one-hot ring
//
// Samples the ring on the rising edge (the ring itself moves on the falling
// edge), decodes the active phase, locks after LOCK_CNT consecutive correct
// rotations, counts locked revolutions and lock losses, and pulses resync for
// one cycle whenever a locked ring is seen to misbehave.
//   clk   : clock
//   clear : asynchronous active-low reset
//   mon   : ring_phase_monitor_if slave (ring in, all status out, registered)

module ring_phase_monitor #(
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 clear,
    ring_phase_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             resync_q, resync_d;

    logic       ring_onehot;
    logic       ring_match;
    logic [1:0] ring_enc;

    // x & (x-1) clears the lowest set bit; zero result on a non-zero x means one-hot.
    assign ring_onehot = (mon.ring != 4'd0) && ((mon.ring & (mon.ring - 4'd1)) == 4'd0);
    assign ring_match  = ring_onehot && (mon.ring == {prev_q[2:0], prev_q[3]});

    always_comb begin
        ring_enc = 2'd0;
        if (mon.ring[1])      ring_enc = 2'd1;
        else if (mon.ring[2]) ring_enc = 2'd2;
        else if (mon.ring[3]) ring_enc = 2'd3;
    end

    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        locked_d      = locked_q;
        wrap_d        = 1'b0;
        rev_count_d   = rev_count_q;
        err_count_d   = err_count_q;
        resync_d      = 1'b0;

        // Tracking of the sample itself happens in every state, FAULT included.
        prev_d        = mon.ring;
        phase_valid_d = ring_onehot;
        phase_d       = ring_onehot ? ring_enc : phase_q;

        case (state_q)
            ACQUIRE: begin
                if (ring_match) begin
                    if (match_cnt_q == 4'(LOCK_CNT - 1)) begin
                        state_d     = LOCKED;
                        locked_d    = 1'b1;
                        match_cnt_d = 4'd0;
                    end else begin
                        match_cnt_d = match_cnt_q + 4'd1;
                    end
                end else begin
                    match_cnt_d = 4'd0;
                end
            end
            LOCKED: begin
                if (ring_match) begin
                    if (mon.ring == 4'b0001) begin
                        wrap_d      = 1'b1;
                        rev_count_d = rev_count_q + REV_W'(1);
                    end
                end else begin
                    state_d  = FAULT;
                    locked_d = 1'b0;
                    resync_d = 1'b1;
                    if (err_count_q != {ERR_W{1'b1}}) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
            end
            FAULT: begin
                // The sample taken here is deliberately not checked: the ring is
                // being re-cleared and may legitimately jump.
                state_d     = ACQUIRE;
                match_cnt_d = 4'd0;
            end
            default: begin
                state_d     = ACQUIRE;
                match_cnt_d = 4'd0;
                locked_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q       <= ACQUIRE;
            prev_q        <= 4'b0001;
            match_cnt_q   <= 4'd0;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            wrap_q        <= 1'b0;
            rev_count_q   <= '0;
            err_count_q   <= '0;
            resync_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            match_cnt_q   <= match_cnt_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            wrap_q        <= wrap_d;
            rev_count_q   <= rev_count_d;
            err_count_q   <= err_count_d;
            resync_q      <= resync_d;
        end
    end

    assign mon.phase       = phase_q;
    assign mon.phase_valid = phase_valid_q;
    assign mon.locked      = locked_q;
    assign mon.wrap        = wrap_q;
    assign mon.rev_count   = rev_count_q;
    assign mon.err_count   = err_count_q;
    assign mon.resync      = resync_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - scoreboard bench for ring_phase_monitor

module tb_ring_phase_monitor;

    localparam int REV_W    = 8;
    localparam int ERR_W    = 4;
    localparam int LOCK_CNT = 4;

    logic clk   = 1'b0;
    logic clear = 1'b0;

    ring_phase_monitor_if #(.REV_W(REV_W), .ERR_W(ERR_W)) bus ();

    ring_phase_monitor #(
        .REV_W    (REV_W),
        .ERR_W    (ERR_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .mon   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       phase;
        logic             pv;
        logic             locked;
        logic             wrap;
        logic             resync;
        logic [REV_W-1:0] rev;
        logic [ERR_W-1:0] err;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    int wraps_seen;
    logic [ERR_W-1:0] err_before;

    // Reference behaviour
    int               m_state;   // 0 acquire, 1 locked, 2 fault
    logic [3:0]       m_prev;
    int               m_run;
    logic [1:0]       m_phase;
    logic             m_pv, m_locked, m_wrap, m_resync;
    logic [REV_W-1:0] m_rev;
    logic [ERR_W-1:0] m_err;

    task automatic model_reset();
        m_state  = 0;
        m_prev   = 4'b0001;
        m_run    = 0;
        m_phase  = 2'd0;
        m_pv     = 1'b0;
        m_locked = 1'b0;
        m_wrap   = 1'b0;
        m_resync = 1'b0;
        m_rev    = '0;
        m_err    = '0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic oh;
        logic good;
        oh   = ($countones(r) == 1);
        good = oh && (r == {m_prev[2:0], m_prev[3]});
        m_wrap   = 1'b0;
        m_resync = 1'b0;
        if (m_state == 0) begin
            m_run = good ? m_run + 1 : 0;
            if (m_run == LOCK_CNT) begin
                m_state  = 1;
                m_locked = 1'b1;
                m_run    = 0;
            end
        end else if (m_state == 1) begin
            if (good) begin
                if (r == 4'b0001) begin
                    m_wrap = 1'b1;
                    m_rev  = m_rev + 1'b1;
                end
            end else begin
                m_state  = 2;
                m_locked = 1'b0;
                m_resync = 1'b1;
                if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
            end
        end else begin
            m_state = 0;
            m_run   = 0;
        end
        m_prev = r;
        m_pv   = oh;
        if (oh) begin
            for (int b = 0; b < 4; b++) if (r[b]) m_phase = 2'(b);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one ring value on the falling edge, compare after the next rising edge.
    task automatic drive(input logic [3:0] r);
        exp_t e;
        exp_t o;
        @(negedge clk);
        bus.ring = r;
        model_step(r);
        e.phase = m_phase; e.pv = m_pv; e.locked = m_locked; e.wrap = m_wrap;
        e.resync = m_resync; e.rev = m_rev; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("phase",       32'(bus.phase),       32'(o.phase));
        chk("phase_valid", 32'(bus.phase_valid), 32'(o.pv));
        chk("locked",      32'(bus.locked),      32'(o.locked));
        chk("wrap",        32'(bus.wrap),        32'(o.wrap));
        chk("resync",      32'(bus.resync),      32'(o.resync));
        chk("rev_count",   32'(bus.rev_count),   32'(o.rev));
        chk("err_count",   32'(bus.err_count),   32'(o.err));
        if (bus.wrap) wraps_seen++;
    endtask

    task automatic next_ring();
        logic [3:0] v;
        v = 4'b0001 << pos;
        drive(v);
        pos = (pos + 1) % 4;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phase"},  32'(bus.phase),       32'd0);
        chk({tag, "_pv"},     32'(bus.phase_valid), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked),      32'd0);
        chk({tag, "_wrap"},   32'(bus.wrap),        32'd0);
        chk({tag, "_rev"},    32'(bus.rev_count),   32'd0);
        chk({tag, "_err"},    32'(bus.err_count),   32'd0);
        chk({tag, "_resync"}, 32'(bus.resync),      32'd0);
    endtask

    // Release clear away from an edge, then run the ring from 0001.
    task automatic release_and_lock(input string tag);
        bus.ring = 4'b0001;
        @(posedge clk);
        #2;
        clear = 1'b1;
        model_reset();
        pos = 0;
        for (int i = 1; i <= LOCK_CNT + 1; i++) begin
            next_ring();
            chk({tag, "_phase_seq"}, 32'(bus.phase), 32'((i - 1) % 4));
            chk({tag, "_lock_time"}, 32'(bus.locked), (i == LOCK_CNT + 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        clear = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ring = 4'b0001;
        model_reset();
        wraps_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Reset and lock
        release_and_lock("lock");

        // 40 locked cycles: 10 single-cycle wraps aligned with phase 0
        wraps_seen = 0;
        repeat (40) begin
            next_ring();
            if (bus.wrap) chk("wrap_phase", 32'(bus.phase), 32'd0);
        end
        chk("wrap_count", 32'(wraps_seen), 32'd10);
        chk("rev_10", 32'(bus.rev_count), 32'd10);

        // Complete 256 revolutions: counter wraps back to zero
        repeat (246 * 4) next_ring();
        chk("rev_wrap", 32'(bus.rev_count), 32'd0);

        // Corruption with 0011 while locked
        drive(4'b0011);
        pos = (pos + 1) % 4;
        chk("corrupt_pv",     32'(bus.phase_valid), 32'd0);
        chk("corrupt_locked", 32'(bus.locked),      32'd0);
        chk("corrupt_resync", 32'(bus.resync),      32'd1);
        chk("corrupt_err",    32'(bus.err_count),   32'd1);
        for (int i = 1; i <= LOCK_CNT + 1; i++) begin
            next_ring();
            if (i == 1) chk("resync_one_cycle", 32'(bus.resync), 32'd0);
            if (i == LOCK_CNT) chk("relock_early", 32'(bus.locked), 32'd0);
            if (i == LOCK_CNT + 1) chk("relock", 32'(bus.locked), 32'd1);
        end

        // Stuck ring at 0100
        while (pos != 2) next_ring();
        next_ring();
        err_before = bus.err_count;
        drive(4'b0100);
        chk("stuck_locked", 32'(bus.locked),    32'd0);
        chk("stuck_wrap",   32'(bus.wrap),      32'd0);
        chk("stuck_err",    32'(bus.err_count), 32'd2);
        chk("stuck_err_inc", 32'(bus.err_count), 32'(err_before) + 32'd1);
        repeat (LOCK_CNT + 1) next_ring();
        chk("stuck_relock", 32'(bus.locked), 32'd1);

        // 20 faults: error counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            drive(4'b0000);
            pos = (pos + 1) % 4;
            if (k == 12) chk("err_reach_max", 32'(bus.err_count), 32'd15);
            repeat (LOCK_CNT + 1) next_ring();
        end
        chk("err_saturated", 32'(bus.err_count), 32'd15);

        // Clear asserted during the FAULT cycle
        drive(4'b1001);
        pos = (pos + 1) % 4;
        chk("fault_resync", 32'(bus.resync), 32'd1);
        async_reset("rst_fault");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        release_and_lock("relock_fault");

        // Clear asserted mid-lock
        repeat (6) next_ring();
        async_reset("rst_lock");
        release_and_lock("relock_mid");
        wraps_seen = 0;
        repeat (8) next_ring();
        chk("post_reset_rev", 32'(bus.rev_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
